// File: rtl/fifo_queue.sv
// fifo_queue: single-clock FIFO with registered output and occupancy flags.
// Words enter at the tail (wr_ptr) and leave from the head (rd_ptr), so they
// come out in arrival order. The flag set matches the companion LIFO stack,
// so control logic can use either buffer without changes.
//
// Optional feature, selected by macro FIFO_QUEUE_ERR_FLAGS_EN:
//   defined   -> overflow/underflow are set by a rejected push/pop and stay
//                set until rst.
//   undefined -> overflow/underflow are tied low and no error logic is built.
// Rejected requests are dropped in both builds.

module fifo_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] In,
  input  logic              push,
  input  logic              pop,
  output logic [DATA_W-1:0] Out,
  output logic              out_valid,
  output logic              empty,
  output logic              full,
  output logic              half_full,
  output logic              three_quarter_full,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DEPTH / 2);
  localparam logic [CNT_W-1:0] CNT_3Q   = CNT_W'((3 * DEPTH) / 4);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Storage is intentionally not reset; stale words are never readable
  // because count gates every pop.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [DATA_W-1:0] out_q,    out_d;
  logic              out_valid_q, out_valid_d;

  logic              pop_acc;
  logic              push_acc;
  logic              not_full;
  logic              not_empty;

  // Accept decisions. A pop frees a slot in the same cycle, so a full queue
  // still takes a push when a pop is accepted alongside it. An empty queue
  // never bypasses: the pop is rejected even if a push arrives with it.
  always_comb begin
    not_full  = (count_q != CNT_FULL);
    not_empty = (count_q != '0);
    pop_acc   = pop & not_empty;
    push_acc  = push & (not_full | pop_acc);
  end

  // Next-state for pointers, occupancy and the registered output word.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (pop_acc) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      out_d       = mem_q[rd_ptr_q];
      out_valid_d = 1'b1;
    end

    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control and output registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage write at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push_acc && !rst) begin
      mem_q[wr_ptr_q] <= In;
    end
  end

  // Occupancy flags decode the count register only, so they describe the
  // state after the most recent edge with no look-ahead.
  always_comb begin
    empty              = (count_q == '0);
    full               = (count_q == CNT_FULL);
    half_full          = (count_q >= CNT_HALF);
    three_quarter_full = (count_q >= CNT_3Q);
  end

  assign Out       = out_q;
  assign out_valid = out_valid_q;

`ifdef FIFO_QUEUE_ERR_FLAGS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error capture: once a request is rejected the flag stays up.
  always_comb begin
    overflow_d  = overflow_q  | (push & ~push_acc);
    underflow_d = underflow_q | (pop  & ~pop_acc);
  end

  // Error flag registers, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_queue.sv
// Directed bench for fifo_queue (DATA_W=32, DEPTH=16). Inputs change 1 time
// unit after a rising edge and outputs are sampled at that same point, well
// away from the active edge.

module tb_fifo_queue;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        push;
  logic        pop;
  logic [31:0] dout;
  logic        out_valid;
  logic        empty;
  logic        full;
  logic        half_full;
  logic        three_quarter_full;
  logic        overflow;
  logic        underflow;

  int checks;
  int errors;

`ifdef FIFO_QUEUE_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  fifo_queue #(.DATA_W(32), .DEPTH(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .In                (din),
    .push              (push),
    .pop               (pop),
    .Out               (dout),
    .out_valid         (out_valid),
    .empty             (empty),
    .full              (full),
    .half_full         (half_full),
    .three_quarter_full(three_quarter_full),
    .overflow          (overflow),
    .underflow         (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given request, then back to idle.
  task automatic step(input logic p, input logic q, input logic [31:0] d);
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    din  = 32'h0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    push = 1'b0; pop = 1'b0; din = 32'h0;
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || half_full !== 1'b0 || three_quarter_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got e=%b f=%b h=%b tq=%b, need 1 0 0 0", empty, full, half_full, three_quarter_full);
    end
    checks++;
    if (dout !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got Out=%h v=%b, need 0 0", dout, out_valid);
    end
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got ov=%b un=%b, need 0 0", overflow, underflow);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_1_to_16;
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 32'(i));
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 32'(i));
      checks++;
      if (half_full !== (i >= 8) || three_quarter_full !== (i >= 12) || full !== (i == 16) || empty !== 1'b0) begin
        errors++;
        $display("FAIL fill_flags_%0d: got h=%b tq=%b f=%b e=%b, need %b %b %b 0",
                 i, half_full, three_quarter_full, full, empty, i >= 8, i >= 12, i == 16);
      end
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 32'h0);
      checks++;
      if (dout !== 32'(i) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain_%0d: got Out=%h v=%b, need %h 1", i, dout, out_valid, 32'(i));
      end
    end
    checks++;
    if (empty !== 1'b1 || half_full !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got e=%b h=%b, need 1 0", empty, half_full);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (out_valid !== 1'b0 || dout !== 32'd16) begin
      errors++;
      $display("FAIL idle_hold: got Out=%h v=%b, need 10 0", dout, out_valid);
    end
  endtask

  task automatic test_overflow;
    fill_1_to_16();
    step(1'b1, 1'b0, 32'hDEAD);
    checks++;
    if (full !== 1'b1 || out_valid !== 1'b0 || overflow !== ERR_EN) begin
      errors++;
      $display("FAIL overflow: got f=%b v=%b ov=%b, need 1 0 %b", full, out_valid, overflow, ERR_EN);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 32'h0);
      checks++;
      if (dout !== 32'(i) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL ovf_drain_%0d: got Out=%h v=%b, need %h 1", i, dout, out_valid, 32'(i));
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL ovf_empty: got e=%b, need 1", empty);
    end
  endtask

  task automatic test_underflow;
    step(1'b0, 1'b1, 32'h0);
    checks++;
    if (dout !== 32'd16 || out_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_hold: got Out=%h v=%b e=%b, need 10 0 1", dout, out_valid, empty);
    end
    checks++;
    if (underflow !== ERR_EN || overflow !== ERR_EN) begin
      errors++;
      $display("FAIL underflow_flag: got un=%b ov=%b, need %b %b", underflow, overflow, ERR_EN, ERR_EN);
    end
  endtask

  task automatic test_full_push_pop;
    fill_1_to_16();
    step(1'b1, 1'b1, 32'hAAAA);
    checks++;
    if (dout !== 32'd1 || out_valid !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_pp: got Out=%h v=%b f=%b, need 1 1 1", dout, out_valid, full);
    end
    for (int i = 2; i <= 17; i++) begin
      step(1'b0, 1'b1, 32'h0);
      checks++;
      if (dout !== ((i == 17) ? 32'hAAAA : 32'(i)) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL full_pp_drain_%0d: got Out=%h v=%b, need %h 1",
                 i, dout, out_valid, (i == 17) ? 32'hAAAA : 32'(i));
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL full_pp_empty: got e=%b, need 1", empty);
    end
  endtask

  task automatic test_empty_push_pop;
    step(1'b1, 1'b1, 32'h55);
    checks++;
    if (out_valid !== 1'b0 || dout !== 32'hAAAA || empty !== 1'b0 || half_full !== 1'b0) begin
      errors++;
      $display("FAIL empty_pp: got Out=%h v=%b e=%b h=%b, need aaaa 0 0 0", dout, out_valid, empty, half_full);
    end
    step(1'b0, 1'b1, 32'h0);
    checks++;
    if (dout !== 32'h55 || out_valid !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_pp_pop: got Out=%h v=%b e=%b, need 55 1 1", dout, out_valid, empty);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] next_in;
    logic [31:0] next_out;
    next_in  = 32'h100;
    next_out = 32'h100;
    for (int c = 0; c < 40; c++) begin
      if (c % 2 == 0) begin
        step(1'b1, 1'b0, next_in);
        next_in++;
      end else begin
        step(1'b0, 1'b1, 32'h0);
        checks++;
        if (dout !== next_out || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL wrap_%0d: got Out=%h v=%b, need %h 1", c, dout, out_valid, next_out);
        end
        next_out++;
      end
    end
    checks++;
    if (empty !== 1'b1 || next_out !== 32'h114) begin
      errors++;
      $display("FAIL wrap_end: got e=%b next=%h, need 1 114", empty, next_out);
    end
  endtask

  task automatic test_reset_mid;
    step(1'b1, 1'b0, 32'h201);
    step(1'b1, 1'b0, 32'h202);
    push = 1'b1; pop = 1'b1; din = 32'h203;
    step(1'b1, 1'b1, 32'h203);
    push = 1'b1; pop = 1'b1; din = 32'h204;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || dout !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got e=%b Out=%h v=%b, need 1 0 0", empty, dout, out_valid);
    end
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_err: got ov=%b un=%b, need 0 0", overflow, underflow);
    end
    push = 1'b0; pop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 32'h77);
    step(1'b0, 1'b1, 32'h0);
    checks++;
    if (dout !== 32'h77 || out_valid !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: got Out=%h v=%b e=%b, need 77 1 1", dout, out_valid, empty);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_queue.md
# fifo_queue

Synchronous first-in/first-out queue that pairs with the existing LIFO stack: words are written at the tail and read from the head, so data leaves in arrival order. It sits between a 32-bit producer and consumer in the same clock domain and exposes the same occupancy flags as the stack. This lets control logic swap between the two buffers without changes.

## Interface
- DATA_W, 32, word width in bits
- DEPTH, 16, number of entries; power of two, ≥ 4
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- In  input  DATA_W  write data, sampled when push is accepted
- push  input  1  enqueue request
- pop  input  1  dequeue request
- Out  output  DATA_W  registered dequeued word
- out_valid  output  1  one-cycle pulse: Out updated this cycle
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- half_full  output  1  count ≥ DEPTH/2
- three_quarter_full  output  1  count ≥ 3*DEPTH/4
- overflow  output  1  push rejected (see Configuration)
- underflow  output  1  pop rejected (see Configuration)

## Operation
- State: storage array DEPTH×DATA_W, wr_ptr and rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH naturally), count (log2(DEPTH)+1 bits, range 0..DEPTH).
- Push accepted when push=1 and (count<DEPTH or pop accepted in same cycle): mem[wr_ptr] ← In, wr_ptr+1.
- Pop accepted when pop=1 and count>0: Out ← mem[rd_ptr], rd_ptr+1, out_valid=1 next cycle.
- Count update: +1 push only, −1 pop only, unchanged for both or neither.
- Simultaneous push+pop:
  - Full: both accepted; count stays DEPTH.
  - Empty: push accepted, pop rejected; never a bypass, Out unchanged.
  - Otherwise: both accepted.
- Rejected push (full, no pop): storage, pointers, count unchanged.
- Rejected pop (empty): Out holds, out_valid=0.
- Out holds its last value whenever no pop is accepted.
- Flags combinational from the count register only.
- Reset (any time, including mid-burst):
  - Pointers, count, Out, out_valid, overflow and underflow clear to 0; empty=1, other flags 0.
  - Storage contents are not cleared; in-flight requests are dropped.

## Timing
- Pop latency: 1 cycle. Pop sampled at edge N gives Out/out_valid valid after edge N, for the cycle N..N+1.
- Flags reflect the request at edge N after that edge; no look-ahead.
- Back-to-back pops each cycle stream one word per cycle; out_valid stays high.
- Reset assertion takes effect immediately (asynchronous); first accepted request is at the first rising edge after deassertion.

## Configuration
- Macro FIFO_QUEUE_ERR_FLAGS_EN.
- Defined:
  - overflow sets on a rejected push; underflow sets on a rejected pop.
  - Both are sticky until rst.
- Undefined:
  - overflow and underflow are tied to 0 and no error logic is built.
  - Rejected requests are silently dropped either way.

## Test plan
- Reset, then push 1..16 (DATA_W=32, DEPTH=16) → half_full after 8th, three_quarter_full after 12th, full after 16th; pop 16 → Out = 1,2,…,16 in order, out_valid each cycle, empty=1 at end.
- Fill to 16, push 0xDEAD with no pop → queue unchanged, next 16 pops return 1..16; overflow=1 with macro, 0 without.
- Empty queue, pop → Out holds prior value, out_valid=0; underflow=1 with macro.
- Full queue, push 0xAAAA + pop same cycle → Out=1, count stays 16, 0xAAAA emerges 16th in drain order.
- Empty queue, push 0x55 + pop same cycle → out_valid=0, count=1; next pop returns 0x55.
- Pointer wrap: 40 cycles of interleaved single push/pop with incrementing data → Out sequence strictly incrementing, no loss or duplication. Assert rst mid-sequence → empty=1, Out=0 immediately.
